// File: rtl/tty_pkg.sv
// Shared types and helpers for the tty UART console monitor.
package tty_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  localparam logic [7:0] EOT = 8'h04;

  function automatic int unsigned div_calc(input int unsigned clk, input int unsigned baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/tty_uart_tx.sv
// 8N1 serial transmitter: shift register plus bit counter, DIV clocks per bit.
module tty_uart_tx
  import tty_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start) begin
          state_d = TX_START;
          sh_d    = data;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TX_DATA;
          tx_d    = sh_q[0];
        end
      end
      TX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[1];
          end
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign busy = (state_q != TX_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/tty_uart_monitor.sv
// UART console monitor: receives SRX, flags framing errors, latches finish on EOT, optional echo.
// Define TTY_PRINT_EN to compile a simulation-only console printer.
module tty_uart_monitor
  import tty_pkg::*;
#(
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned ECHO        = 0,
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SRX,
  output logic       STX,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       framing_err,
  output logic       finish,
  output logic       tx_busy,
  output logic       overrun
);

  localparam int unsigned DIV = div_calc(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic [1:0]    sync_q;
  logic          rxs;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          fe_q, fe_d;
  logic          finish_q, finish_d;

  assign rxs = sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q     <= '1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], SRX};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      finish_q   <= finish_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    fe_d       = 1'b0;
    finish_d   = finish_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rxs) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxs, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_WAIT_HIGH;
          if (rxs) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            if (rx_sh_q == EOT) finish_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low break parks here so it cannot look like a new start bit.
        rx_cnt_d = '0;
        if (rxs) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign framing_err = fe_q;
  assign finish      = finish_q;

  if (ECHO != 0) begin : g_echo
    logic       tx_start, tx_busy_w, tx_line;
    logic [7:0] tx_byte;
    logic       hold_v_q, hold_v_d;
    logic [7:0] hold_q, hold_d;
    logic       ovr_q, ovr_d;

    // An idle transmitter drains the holding byte first; a byte arriving in that
    // same cycle refills the holding register so ordering is preserved.
    always_comb begin
      tx_start = 1'b0;
      tx_byte  = rx_data_q;
      hold_v_d = hold_v_q;
      hold_d   = hold_q;
      ovr_d    = 1'b0;
      if (!tx_busy_w) begin
        if (hold_v_q) begin
          tx_start = 1'b1;
          tx_byte  = hold_q;
          hold_v_d = rx_valid_q;
          if (rx_valid_q) hold_d = rx_data_q;
        end else if (rx_valid_q) begin
          tx_start = 1'b1;
        end
      end else if (rx_valid_q) begin
        if (!hold_v_q) begin
          hold_v_d = 1'b1;
          hold_d   = rx_data_q;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        hold_v_q <= 1'b0;
        hold_q   <= '0;
        ovr_q    <= 1'b0;
      end else begin
        hold_v_q <= hold_v_d;
        hold_q   <= hold_d;
        ovr_q    <= ovr_d;
      end
    end

    tty_uart_tx #(.DIV(DIV)) u_tx (
      .clock (clock),
      .reset (reset),
      .start (tx_start),
      .data  (tx_byte),
      .busy  (tx_busy_w),
      .tx    (tx_line)
    );

    assign STX     = tx_line;
    assign tx_busy = tx_busy_w;
    assign overrun = ovr_q;
  end else begin : g_no_echo
    assign STX     = 1'b1;
    assign tx_busy = 1'b0;
    assign overrun = 1'b0;
  end

`ifdef TTY_PRINT_EN
  logic fin_seen_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fin_seen_q <= 1'b0;
    end else begin
      fin_seen_q <= finish_q;
      if (rx_valid_q) $write("%c", rx_data_q);
      if (fe_q) $write("[tty framing error]");
      if (finish_q && !fin_seen_q) $write("[tty finish]");
    end
  end
`endif

endmodule

// File: tb/tb_tty_uart_monitor.sv
// Directed bench for tty_uart_monitor with DIV=10; one ECHO=0 and one ECHO=1 instance share SRX.
module tb_tty_uart_monitor;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic SRX   = 1'b1;

  logic       stx0, rxv0, fe0, fin0, busy0, ovr0;
  logic [7:0] rxd0;
  logic       stx1, rxv1, fe1, fin1, busy1, ovr1;
  logic [7:0] rxd1;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned last_fall = 0;

  int unsigned v0_n = 0, v0_cyc = 0, fe0_n = 0, fe0_cyc = 0, fin_rise = 0;
  int unsigned v1_n = 0, ov1_n = 0, ov1_cyc = 0, bad0_n = 0;
  int unsigned stx1_fall = 0, busy1_rise = 0;
  logic [7:0]  v0_data = 8'h00;
  logic        fin0_prev = 1'b0, stx1_prev = 1'b1, busy1_prev = 1'b0;
  logic [9:0]  frv;

  tty_uart_monitor #(.BAUD_RATE(115200), .ECHO(0), .CLK_FREQ_HZ(1_152_000)) u_dut0 (
    .clock(clock), .reset(reset), .SRX(SRX), .STX(stx0), .rx_valid(rxv0), .rx_data(rxd0),
    .framing_err(fe0), .finish(fin0), .tx_busy(busy0), .overrun(ovr0)
  );

  tty_uart_monitor #(.BAUD_RATE(115200), .ECHO(1), .CLK_FREQ_HZ(1_152_000)) u_dut1 (
    .clock(clock), .reset(reset), .SRX(SRX), .STX(stx1), .rx_valid(rxv1), .rx_data(rxd1),
    .framing_err(fe1), .finish(fin1), .tx_busy(busy1), .overrun(ovr1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rxv0) begin v0_n <= v0_n + 1; v0_cyc <= cyc; v0_data <= rxd0; end
    if (fe0) begin fe0_n <= fe0_n + 1; fe0_cyc <= cyc; end
    if (fin0 && !fin0_prev) fin_rise <= cyc;
    fin0_prev <= fin0;
    if (rxv1) v1_n <= v1_n + 1;
    if (ovr1) begin ov1_n <= ov1_n + 1; ov1_cyc <= cyc; end
    if (ovr0 || busy0 || !stx0) bad0_n <= bad0_n + 1;
    if (!stx1 && stx1_prev) stx1_fall <= cyc;
    stx1_prev <= stx1;
    if (busy1 && !busy1_prev) busy1_rise <= cyc;
    busy1_prev <= busy1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, observed cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  // Drives {stop, data, start} LSB first at 10 cycles/bit for ncyc cycles, then idles high.
  task automatic send(input logic [7:0] b, input logic stopv, input int unsigned ncyc);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    last_fall = cyc;
    for (int unsigned k = 0; k < ncyc; k++) begin
      SRX = fr[k / 10];
      @(negedge clock);
    end
    SRX = 1'b1;
  endtask

  initial begin
    wait_n(3);
    chk("reset_vec0", {18'd0, stx0, rxv0, rxd0, fe0, fin0, busy0, ovr0}, 32'h2000);
    chk("reset_vec1", {18'd0, stx1, rxv1, rxd1, fe1, fin1, busy1, ovr1}, 32'h2000);
    reset = 1'b0;
    wait_n(5);

    send(8'h41, 1'b1, 100);
    wait_n(5);
    chk("rx41_count", v0_n, 1);
    chk("rx41_data", v0_data, 8'h41);
    chk("rx41_latency", v0_cyc, last_fall + 98);
    chk("rx41_finish", fin0, 1'b0);
    chk("rx41_count_echo_dut", v1_n, 1);
    wait_n(110);

    send(8'h55, 1'b0, 100);
    wait_n(5);
    chk("fe55_count", fe0_n, 1);
    chk("fe55_cycle", fe0_cyc, last_fall + 98);
    chk("fe55_no_valid", v0_n, 1);
    chk("fe55_data_kept", rxd0, 8'h41);
    chk("fe55_no_echo", busy1, 1'b0);

    send(8'h04, 1'b0, 100);
    wait_n(5);
    chk("fe04_no_finish", fin0, 1'b0);
    chk("fe04_count", fe0_n, 2);

    SRX = 1'b0;
    wait_n(3);
    SRX = 1'b1;
    wait_n(20);
    chk("glitch_no_valid", v0_n, 1);
    chk("glitch_no_fe", fe0_n, 2);
    send(8'h0A, 1'b1, 100);
    wait_n(5);
    chk("rx0a_count", v0_n, 2);
    chk("rx0a_data", v0_data, 8'h0A);
    wait_n(110);

    send(8'h04, 1'b1, 100);
    wait_n(5);
    chk("eot_finish", fin0, 1'b1);
    chk("eot_same_cycle", fin_rise, v0_cyc);
    chk("eot_data", v0_data, 8'h04);
    wait_n(110);
    send(8'h41, 1'b1, 100);
    wait_n(5);
    chk("finish_sticky", fin0, 1'b1);
    chk("finish_sticky_data", v0_data, 8'h41);
    wait_n(110);

    reset = 1'b1;
    #1;
    chk("reset_clears_finish", fin0, 1'b0);
    wait_n(2);
    reset = 1'b0;
    wait_n(5);

    send(8'hA5, 1'b1, 100);
    frv = {1'b1, 8'hA5, 1'b0};
    while (cyc != last_fall + 104) @(negedge clock);
    chk("echo_start_cycle", stx1_fall, last_fall + 99);
    chk("echo_busy_rise", busy1_rise, last_fall + 99);
    for (int b = 0; b < 10; b++) begin
      while (cyc != last_fall + 104 + 10 * b) @(negedge clock);
      chk($sformatf("echo_bit%0d", b), stx1, frv[b]);
    end
    while (cyc != last_fall + 205) @(negedge clock);
    chk("echo_idle_busy", busy1, 1'b0);
    chk("echo_idle_line", stx1, 1'b1);

    for (int k = 0; k < 27; k++) send(8'h30 + 8'(k), 1'b1, 97);
    wait_n(5);
    chk("burst_overrun_count", ov1_n, 1);
    chk("burst_overrun_cycle", ov1_cyc, last_fall + 99);
    chk("burst_rx_count", v1_n, 32);
    chk("burst_rx_count0", v0_n, 32);
    chk("burst_last_data", v0_data, 8'h4A);
    wait_n(300);
    chk("burst_drained", busy1, 1'b0);

    send(8'h33, 1'b1, 100);
    send(8'h5C, 1'b1, 45);
    chk("midframe_tx_busy", busy1, 1'b1);
    reset = 1'b1;
    #1;
    chk("midframe_reset_vec0", {18'd0, stx0, rxv0, rxd0, fe0, fin0, busy0, ovr0}, 32'h2000);
    chk("midframe_reset_vec1", {18'd0, stx1, rxv1, rxd1, fe1, fin1, busy1, ovr1}, 32'h2000);
    wait_n(2);
    reset = 1'b0;
    wait_n(150);
    chk("midframe_no_valid", v0_n, 33);
    chk("midframe_no_fe", fe0_n, 2);
    chk("midframe_data_reset", rxd0, 8'h00);
    chk("echo0_line_quiet", bad0_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tty_uart_monitor.md
# tty_uart_monitor

Synthesizable UART console monitor for the SoC test harness. It receives the SoC's serial TX line, presents each received byte and flags framing errors. A received EOT byte latches a sticky `finish` flag, which the harness uses as its completion indication. It can optionally echo received bytes back on its own TX line.

## Interface
Parameters:
- `BAUD_RATE`, default 115200: line bit rate.
- `ECHO`, default 0: when 1, retransmit each cleanly received byte on `STX`.
- `CLK_FREQ_HZ`, default 100_000_000: `clock` frequency.
  - `DIV = CLK_FREQ_HZ / BAUD_RATE`, truncated; must be ≥ 4.

Ports:
- `clock` in 1: single clock. Reset is asynchronous and active-high.
- `reset` in 1: async active-high reset.
- `SRX` in 1: serial input from the SoC UART TX; idle high.
- `STX` out 1: serial output to the SoC UART RX; idle high.
- `rx_valid` out 1: one-cycle pulse; `rx_data` holds a good byte.
- `rx_data` out 8: last good received byte.
- `framing_err` out 1: one-cycle pulse; stop bit sampled low.
- `finish` out 1: sticky; set on a good 0x04 byte.
- `tx_busy` out 1: echo transmitter is active.
- `overrun` out 1: one-cycle pulse; echo byte dropped.

## Operation
- `SRX` passes through a 2-flop synchronizer (reset value 1) to give `rxs`.
- RX FSM:
  - IDLE: `rxs`=0 → START, counter cleared.
  - START: after DIV/2 cycles, resample. 0 → DATA; 1 → IDLE (glitch, no flags).
  - DATA: sample 8 bits LSB first, one every DIV cycles.
  - STOP: sample DIV cycles after bit 7.
    - Sample 1 → load `rx_data`, pulse `rx_valid`.
    - Sample 0 → pulse `framing_err`, `rx_data` unchanged.
  - STOP → WAIT_HIGH, then to IDLE once `rxs`=1. A break (line held low) never retriggers.
- `finish`: set in the same cycle as an `rx_valid` carrying 0x04. Cleared only by `reset`. Framing-error bytes never set it.
- Echo path (ECHO=1):
  - On `rx_valid`, the byte goes to the transmitter if idle.
  - If the transmitter is busy: the byte goes to a 1-entry holding register if empty; otherwise `overrun` pulses and the byte is dropped.
  - Frame: start 0, 8 data bits LSB first, stop 1; each bit lasts DIV cycles.
  - The holding register launches the cycle after the previous stop bit ends.
- ECHO=0: `STX` is constant 1, `tx_busy` is 0, `overrun` is 0.

## Timing
- Reset values: `STX`=1, `rx_valid`=0, `rx_data`=0x00, `framing_err`=0, `finish`=0, `tx_busy`=0, `overrun`=0. RX FSM in IDLE.
- Cycle T0 is the first cycle with `rxs`=0 (2 cycles after `SRX` falls):
  - start check at T0+DIV/2;
  - data bit i sampled at T0+DIV/2+(i+1)·DIV;
  - stop bit sampled at T0+DIV/2+9·DIV;
  - `rx_valid`/`framing_err` high in the following cycle.
- Echo: `STX` drives the start bit the cycle after `rx_valid`; `tx_busy` rises in the same cycle.
- Reset mid-frame aborts RX and TX immediately. `STX` returns to 1 and no partial byte is reported.

## Configuration
- `TTY_PRINT_EN` defined: simulation-only block `$write`s each good byte as a character. A framing error prints "[tty framing error]". On `finish` rising, prints "[tty finish]".
- Undefined: no print code compiled; RTL behaviour is identical.

## Structure
- Package `tty_pkg`:
  - RX state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - TX state enum (IDLE, START, DATA, STOP);
  - `EOT` constant = 8'h04;
  - `div_calc(clk, baud)` function.
- Sub-module `tty_uart_tx`: shift register plus bit counter. Ports: `clock`, `reset`, `start`, `data[7:0]`, `busy`, `tx`. Instantiated only when ECHO=1.

## Test plan
Run with CLK_FREQ_HZ=1_152_000 and BAUD_RATE=115200, giving DIV=10.
- Frame 0x41 on `SRX` → one `rx_valid` pulse with `rx_data`=0x41 at T0+95+1; `finish` stays 0.
- Frame 0x55 with stop bit 0 → `framing_err` pulse; `rx_valid` stays 0; `rx_data` keeps its prior value.
- `SRX` low pulse of 3 cycles → no flags; FSM back in IDLE, and the next good frame 0x0A is received correctly.
- Frame 0x04 → `finish`=1 and it stays 1 through later frames; asserting `reset` clears it.
- ECHO=1, frame 0xA5 → `STX` reproduces 0 1010 0101-LSB-first 1 at 10 cycles/bit, starting the cycle after `rx_valid`. Three back-to-back frames arriving while the TX is blocked → one `overrun` pulse.
- `reset` asserted during data bit 3 → all outputs return to reset values within the same cycle and no `rx_valid` occurs.
